// File: rtl/rr_mux4_arbiter_if.sv
// Request/data/grant bundle between four sources and the round-robin mux arbiter.
// The lock line exists only when MUX_ARB_LOCK_EN is defined.
interface rr_mux4_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       gnt;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             busy;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;

    modport master (output req, a, b, c, d, lock,
                    input  gnt, s1, s0, y, y_valid, busy);
    modport slave  (input  req, a, b, c, d, lock,
                    output gnt, s1, s0, y, y_valid, busy);
`else
    modport master (output req, a, b, c, d,
                    input  gnt, s1, s0, y, y_valid, busy);
    modport slave  (input  req, a, b, c, d,
                    output gnt, s1, s0, y, y_valid, busy);
`endif
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux, with bounded tenure of HOLD_MAX cycles.
// Optional MUX_ARB_LOCK_EN adds a lock input that extends a tenure past HOLD_MAX.
module rr_mux4_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    rr_mux4_arbiter_if.slave    bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    // First requester found scanning upward from last+1; the previous owner is checked last.
    function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    state_t           state_r, next_state_s;
    logic [3:0]       gnt_r, next_gnt_s;
    logic [1:0]       sel_r, next_sel_s;
    logic [1:0]       last_r, next_last_s;
    logic [7:0]       hold_r, next_hold_s, hold_inc_s;
    logic [WIDTH-1:0] y_r, mux_s;
    logic             y_valid_r, busy_r;
    logic             owner_req_s, hold_done_s, release_s;
    logic [1:0]       winner_s;

    assign owner_req_s = bus.req[last_r];
    assign winner_s    = pick_winner(bus.req, last_r);
    assign release_s   = !owner_req_s || hold_done_s;

`ifdef MUX_ARB_LOCK_EN
    // Lock only matters once the tenure limit is reached; the counter then parks at its top.
    assign hold_done_s = (hold_r == HOLD_LAST) && !bus.lock;
    assign hold_inc_s  = (hold_r == HOLD_LAST) ? hold_r : hold_r + 8'd1;
`else
    assign hold_done_s = (hold_r == HOLD_LAST);
    assign hold_inc_s  = hold_r + 8'd1;
`endif

    // Next-state and next-grant decision for the arbitration FSM.
    always_comb begin
        next_state_s = state_r;
        next_gnt_s   = gnt_r;
        next_sel_s   = sel_r;
        next_last_s  = last_r;
        next_hold_s  = hold_r;
        case (state_r)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    next_state_s = GRANT;
                    next_gnt_s   = 4'b0001 << winner_s;
                    next_sel_s   = winner_s;
                    next_last_s  = winner_s;
                    next_hold_s  = 8'd0;
                end else begin
                    next_gnt_s   = 4'b0000;
                end
            end
            GRANT: begin
                if (release_s) begin
                    if (bus.req != 4'b0000) begin
                        next_state_s = GRANT;
                        next_gnt_s   = 4'b0001 << winner_s;
                        next_sel_s   = winner_s;
                        next_last_s  = winner_s;
                        next_hold_s  = 8'd0;
                    end else begin
                        next_state_s = IDLE;
                        next_gnt_s   = 4'b0000;
                        next_hold_s  = 8'd0;
                    end
                end else begin
                    next_hold_s = hold_inc_s;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_gnt_s   = 4'b0000;
                next_hold_s  = 8'd0;
            end
        endcase
    end

    // Source data selected by the currently registered owner index.
    always_comb begin
        mux_s = '0;
        case (sel_r)
            2'd0:    mux_s = bus.a;
            2'd1:    mux_s = bus.b;
            2'd2:    mux_s = bus.c;
            2'd3:    mux_s = bus.d;
            default: mux_s = '0;
        endcase
    end

    // Arbitration state, grant, select and tenure counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            last_r  <= 2'd3;
            hold_r  <= 8'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            gnt_r   <= next_gnt_s;
            sel_r   <= next_sel_s;
            last_r  <= next_last_s;
            hold_r  <= next_hold_s;
            busy_r  <= (next_state_s == GRANT);
        end
    end

    // Output data register: y holds outside a tenure, valid only while the owner still asks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
        end else if (state_r == GRANT) begin
            y_r       <= mux_s;
            y_valid_r <= owner_req_s;
        end else begin
            y_valid_r <= 1'b0;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.s1      = sel_r[1];
    assign bus.s0      = sel_r[0];
    assign bus.y       = y_r;
    assign bus.y_valid = y_valid_r;
    assign bus.busy    = busy_r;
endmodule
